// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC router output-port logic.
//   - Crossbar port codes (N, S, W, E, L). The east code doubles as the
//     default/no-route select for the east output port.
//   - outport_state_e : output-port arbitration FSM state.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam logic [2:0] PORT_N = 3'b000;
    localparam logic [2:0] PORT_S = 3'b001;
    localparam logic [2:0] PORT_W = 3'b010;
    localparam logic [2:0] PORT_E = 3'b011;
    localparam logic [2:0] PORT_L = 3'b100;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } outport_state_e;

endpackage

// File: rtl/credit_counter.sv
// -----------------------------------------------------------------------------
// credit_counter
// Saturating up/down counter tracking free slots in the downstream buffer.
// Starts full (CREDIT_DEPTH). inc and dec in the same cycle cancel out.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inc        : one slot returned by downstream
//   dec        : one slot consumed by a forwarded flit
//   count      : current credit count
//   zero, full : count == 0, count == CREDIT_DEPTH
// -----------------------------------------------------------------------------
module credit_counter #(
    parameter int CREDIT_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              inc,
    input  logic                              dec,
    output logic [$clog2(CREDIT_DEPTH+1)-1:0] count,
    output logic                              zero,
    output logic                              full
);

    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    assign zero = (count == '0);
    assign full = (count == CW'(CREDIT_DEPTH));

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CW'(CREDIT_DEPTH);
        end else if (inc && !dec && !full) begin
            count <= count + CW'(1);
        end else if (dec && !inc && !zero) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/e_outport_ctrl.sv
// -----------------------------------------------------------------------------
// e_outport_ctrl
// East output-port controller: locks the crossbar onto the granted input port
// for the length of one packet, forwards flits while downstream credit is
// available and rotates the round-robin order once the tail has gone out.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   rrp_e_priority_to_cs_i [2:0] : winning port code from the east RR processor
//   rrp_e_priority_{n,s,w,l}_i   : per-port grants from the east RR processor
//   flit_valid_i, flit_tail_i    : selected input buffer has a flit / it is a tail
//   credit_return_i              : downstream freed one slot
//   cs_e_sel_o [2:0]             : crossbar select for the east output
//   cs_e_valid_o, flit_pop_o     : flit forwarded this cycle / dequeue it
//   rr_register_change_order_o   : one-cycle pulse after a tail is forwarded
//   rr_downstream_credit_o       : east can accept a new grant
//   credit_err_o                 : sticky protocol error (credit overflow or
//                                  multiple grants while idle)
// Configuration: define E_OUTPORT_ERR_CHECK_EN to enable credit_err_o;
// otherwise it is tied low.
// -----------------------------------------------------------------------------
module e_outport_ctrl
    import noc_pkg::*;
#(
    parameter int CREDIT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rrp_e_priority_to_cs_i,
    input  logic       rrp_e_priority_n_i,
    input  logic       rrp_e_priority_s_i,
    input  logic       rrp_e_priority_w_i,
    input  logic       rrp_e_priority_l_i,
    input  logic       flit_valid_i,
    input  logic       flit_tail_i,
    input  logic       credit_return_i,
    output logic [2:0] cs_e_sel_o,
    output logic       cs_e_valid_o,
    output logic       flit_pop_o,
    output logic       rr_register_change_order_o,
    output logic       rr_downstream_credit_o,
    output logic       credit_err_o
);

    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    outport_state_e state, state_next;

    logic [CW-1:0] credit;
    logic          credit_zero;
    logic          credit_full;
    logic [2:0]    grant_count;
    logic          one_grant;
    logic          multi_grant;
    logic          forward;
    logic          capture;

    assign grant_count = {2'b00, rrp_e_priority_n_i} + {2'b00, rrp_e_priority_s_i}
                       + {2'b00, rrp_e_priority_w_i} + {2'b00, rrp_e_priority_l_i};
    assign one_grant   = (grant_count == 3'd1);
    assign multi_grant = (grant_count > 3'd1);

    // A grant is only accepted when downstream has room for at least one flit.
    assign capture = (state == ST_IDLE) && one_grant && !credit_zero;
    assign forward = (state == ST_LOCKED) && flit_valid_i && !credit_zero;

    assign cs_e_valid_o           = forward;
    assign flit_pop_o             = forward;
    assign rr_downstream_credit_o = (state == ST_IDLE) && !credit_zero;

    credit_counter #(
        .CREDIT_DEPTH (CREDIT_DEPTH)
    ) u_credit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (credit_return_i),
        .dec   (forward),
        .count (credit),
        .zero  (credit_zero),
        .full  (credit_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (capture) state_next = ST_LOCKED;
            ST_LOCKED: if (forward && flit_tail_i) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Select is captured with the grant and held for the whole packet; it
    // keeps its last value while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_e_sel_o <= PORT_E;
        end else if (capture) begin
            cs_e_sel_o <= rrp_e_priority_to_cs_i;
        end
    end

    // Reset clears this flop, so a packet abandoned by reset never pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_register_change_order_o <= 1'b0;
        end else begin
            rr_register_change_order_o <= forward && flit_tail_i;
        end
    end

`ifdef E_OUTPORT_ERR_CHECK_EN
    logic credit_overflow;
    // A return that would push the count past CREDIT_DEPTH; a same-cycle
    // forward absorbs it.
    assign credit_overflow = credit_return_i && credit_full && !forward;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_err_o <= 1'b0;
        end else if (credit_overflow || ((state == ST_IDLE) && multi_grant)) begin
            credit_err_o <= 1'b1;
        end
    end
`else
    logic unused_err_inputs;
    assign unused_err_inputs = &{1'b0, credit_full, multi_grant};
    assign credit_err_o      = 1'b0;
`endif

endmodule

// File: doc/e_outport_ctrl.md
E_OUTPORT_CTRL -- requirements
Module: e_outport_ctrl

Interface
REQ-001 Parameter: CREDIT_DEPTH, default 4, number of flit slots in the downstream (east neighbour) input buffer.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rrp_e_priority_to_cs_i  input  3  winning-port code from east round-robin processor.
REQ-005 rrp_e_priority_n_i / _s_i / _w_i / _l_i  input  1 each  per-port grant from east round-robin processor.
REQ-006 flit_valid_i  input  1  selected input buffer holds a flit for east.
REQ-007 flit_tail_i  input  1  the presented flit is a packet tail.
REQ-008 credit_return_i  input  1  downstream freed one slot (1-cycle pulse).
REQ-009 cs_e_sel_o  output  3  crossbar select for east output, port code.
REQ-010 cs_e_valid_o  output  1  flit driven onto east link this cycle.
REQ-011 flit_pop_o  output  1  dequeue to the selected input buffer.
REQ-012 rr_register_change_order_o  output  1  rotates the round-robin registers.
REQ-013 rr_downstream_credit_o  output  1  east may accept a new grant.
REQ-014 credit_err_o  output  1  sticky protocol-error flag.

Function
REQ-015 FSM states IDLE and LOCKED; reset state IDLE.
REQ-016 IDLE -> LOCKED when exactly one grant input is high and credit count is nonzero; cs_e_sel_o registers rrp_e_priority_to_cs_i on that edge.
REQ-017 In LOCKED, cs_e_sel_o holds and further grant inputs are ignored.
REQ-018 cs_e_valid_o = flit_pop_o = LOCKED & flit_valid_i & (credit != 0), combinational, zero-cycle latency.
REQ-019 Forwarded flit with flit_tail_i high: LOCKED -> IDLE next edge; rr_register_change_order_o pulses high for exactly that following cycle.
REQ-020 Single-flit packet (head = tail) takes one cycle in LOCKED; back-to-back packets give minimum 1 IDLE cycle between them.
REQ-021 Credit count width clog2(CREDIT_DEPTH+1); reset value CREDIT_DEPTH; decrements on forwarded flit, increments on credit_return_i; both in one cycle leaves it unchanged.
REQ-022 Credit zero in LOCKED: flit stalls, state holds, no pop.
REQ-023 credit_return_i at count CREDIT_DEPTH (no simultaneous forward): count saturates, credit_err_o set.
REQ-024 More than one grant input high in IDLE: no transition, credit_err_o set.
REQ-025 rr_downstream_credit_o = IDLE & (credit != 0).

Reset
REQ-026 On reset: state IDLE, cs_e_sel_o 3'b011 (east, the default/no-route code), credit CREDIT_DEPTH, credit_err_o 0, all pulse/valid outputs 0.
REQ-027 Reset mid-packet abandons the packet; no change-order pulse is produced for it.
REQ-028 credit_err_o clears only on reset.

Configuration
REQ-029 Macro E_OUTPORT_ERR_CHECK_EN defined: REQ-023/REQ-024 error detection active.
REQ-030 Macro absent: credit_err_o tied 0, multi-grant behaviour per REQ-024 unchanged except flag, saturation still applies.

Structure
REQ-031 Shared package noc_pkg holds port-code constants (N 000, S 001, W 010, E 011, L 100) and the outport FSM state enum.
REQ-032 One sub-module: credit_counter (saturating up/down counter, parameter CREDIT_DEPTH, zero/full flags).

Verification
REQ-033 Reset, no activity -> cs_e_sel_o 3'b011, rr_downstream_credit_o 1, credit 4.
REQ-034 Grant N (code 000), 3-flit packet, flit_valid_i continuous -> three cs_e_valid_o cycles, change_order pulse cycle after tail, back to IDLE.
REQ-035 Grant W, 6-flit packet, no credit returns -> 4 flits pass, stall at credit 0, resume one flit per credit_return_i.
REQ-036 Simultaneous forward and credit_return_i at credit 2 -> credit stays 2.
REQ-037 Grants N and S both high in IDLE -> stays IDLE, credit_err_o 1 (with macro), 0 (without).
REQ-038 Reset asserted during flit 2 of 4 -> immediate IDLE, credit 4, no change_order pulse.
